// File: rtl/md_unit.sv
// Multiply/divide unit: multi-cycle mult/div with architectural HI/LO.
// Results are computed at launch and released after a fixed latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] thi, thi_n, tlo, tlo_n;
    logic [31:0] hi_n, lo_n;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sdiv_b, quo_s, rem_s;
    logic        [31:0] udiv_b, quo_u, rem_u;
    logic               b_zero, b_neg1;

    assign b_zero = (B == 32'd0);
    assign b_neg1 = (B == 32'hFFFF_FFFF);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisors 0 and -1 are steered away from the divider; -1 is
    // handled as negation so INT_MIN / -1 wraps instead of overflowing.
    assign sdiv_b = (b_zero || b_neg1) ? 32'sd1 : $signed(B);
    assign udiv_b = b_zero ? 32'd1 : B;
    assign quo_s  = b_neg1 ? -$signed(A) : $signed(A) / sdiv_b;
    assign rem_s  = b_neg1 ? 32'sd0 : $signed(A) % sdiv_b;
    assign quo_u  = A / udiv_b;
    assign rem_u  = A % udiv_b;

    assign Busy = (state == RUN);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        thi_n   = thi;
        tlo_n   = tlo;
        hi_n    = HI;
        lo_n    = LO;
        unique case (state)
            IDLE: begin
                if (Start && MDOp >= OP_MULT && MDOp <= OP_DIVU) begin
                    state_n = RUN;
                    unique case (MDOp)
                        OP_MULT: begin
                            {thi_n, tlo_n} = prod_s;
                            cnt_n = MULT_N;
                        end
                        OP_MULTU: begin
                            {thi_n, tlo_n} = prod_u;
                            cnt_n = MULT_N;
                        end
                        OP_DIV: begin
                            thi_n = rem_s;
                            tlo_n = quo_s;
                            cnt_n = DIV_N;
                        end
                        default: begin
                            thi_n = rem_u;
                            tlo_n = quo_u;
                            cnt_n = DIV_N;
                        end
                    endcase
                    // Divide by zero retires the current HI/LO unchanged.
                    if (b_zero && MDOp >= OP_DIV) begin
                        thi_n = HI;
                        tlo_n = LO;
                    end
                end else if (!Start && MDOp == OP_MTHI) begin
                    hi_n = A;
                end else if (!Start && MDOp == OP_MTLO) begin
                    lo_n = A;
                end
            end
            RUN: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi_n    = thi;
                    lo_n    = tlo;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            thi   <= 32'd0;
            tlo   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            thi   <= thi_n;
            tlo   <= tlo_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, corner sequences,
// and random traffic checked against a cycle-level reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [2:0] op,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, up;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        res = {hi, lo};
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: begin
                up = ua * ub;
                res = up;
            end
            3'd3: if (b != 0) begin
                q = sa / sb;
                r = sa - q * sb;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) begin
                uq = ua / ub;
                ur = ua - uq * ub;
                res = {ur[31:0], uq[31:0]};
            end
            default: res = {hi, lo};
        endcase
        return res;
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (Start && MDOp >= 1 && MDOp <= 4) begin
            m_pend = ref_calc(MDOp, A, B, m_hi, m_lo);
            m_left = (MDOp <= 2) ? 5 : 10;
        end else if (!Start && MDOp == 3'd5) begin
            m_hi = A;
        end else if (!Start && MDOp == 3'd6) begin
            m_lo = A;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_busy", {31'd0, Busy}, {31'd0, m_left > 0});
        check("model_hi", HI, m_hi);
        check("model_lo", LO, m_lo);
    endtask

    task automatic idle_inputs();
        Start = 0; MDOp = 0; A = 0; B = 0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        Start = 1; MDOp = op; A = a; B = b;
        step();
        idle_inputs();
        n = 0;
        while (Busy && n < 40) begin
            n++;
            step();
        end
    endtask

    vec_t tbl[6];
    int   n;

    initial begin
        tbl[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        tbl[1] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        tbl[2] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        tbl[3] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[4] = '{3'd4, 32'd7, 32'd3, 32'd1, 32'd2, 10};
        tbl[5] = '{3'd4, 32'd5, 32'd0, 32'd1, 32'd2, 10};

        m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0;
        reset = 0;
        idle_inputs();
        #12;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        step();
        #2 reset = 1;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, n);
            check($sformatf("tbl%0d_cycles", i), n, tbl[i].cyc);
            check($sformatf("tbl%0d_hi", i), HI, tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), LO, tbl[i].lo);
        end

        // mthi in IDLE
        MDOp = 3'd5; A = 32'h1234_5678;
        step();
        idle_inputs();
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_busy", {31'd0, Busy}, 32'd0);

        // mtlo and a second Start during a running mult are ignored
        Start = 1; MDOp = 3'd1; A = 32'd6; B = 32'd7;
        step();
        Start = 0; MDOp = 3'd6; A = 32'hDEAD_BEEF;
        step();
        Start = 1; MDOp = 3'd3; A = 32'd100; B = 32'd9;
        step();
        idle_inputs();
        n = 2;
        while (Busy && n < 40) begin
            n++;
            step();
        end
        check("viol_cycles", n, 5);
        check("viol_hi", HI, 32'd0);
        check("viol_lo", LO, 32'd42);
        step();
        check("viol_no_relaunch", {31'd0, Busy}, 32'd0);

        // async reset in the 4th busy cycle of a div
        Start = 1; MDOp = 3'd3; A = 32'hFFFF_FFF9; B = 32'd2;
        step();
        idle_inputs();
        repeat (3) step();
        #2 reset = 0;
        #1;
        m_hi = 0; m_lo = 0; m_left = 0;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        step();
        #2 reset = 1;
        repeat (12) step();
        check("rst_no_late_lo", LO, 32'd0);
        run_op(3'd1, 32'd3, 32'hFFFF_FFFE, n);
        check("post_rst_cycles", n, 5);
        check("post_rst_hi", HI, 32'hFFFF_FFFF);
        check("post_rst_lo", LO, 32'hFFFF_FFFA);

        // random traffic, including protocol violations
        for (int i = 0; i < 400; i++) begin
            Start = ($urandom_range(0, 3) == 0);
            MDOp  = 3'($urandom_range(0, 7));
            A     = $urandom;
            B     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 15) == 0) B = 32'hFFFF_FFFF;
            step();
        end
        idle_inputs();
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the five-stage pipeline. It executes mult, multu, div and divu over several cycles and handles mthi and mtlo writes. It holds the architectural HI/LO registers and drives the Busy flag. The stall control logic combines Busy with Start to freeze PC and the D register and to bubble E whenever an HI/LO-dependent instruction sits in D.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu.
- DIV_CYCLES, default 10: busy cycles for div/divu.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; one clock, asynchronous active-low reset.
- Start  input  1  one-cycle pulse; a valid mult/multu/div/divu is in E this cycle.
- MDOp  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
- A  input  32  rs operand, forwarded value.
- B  input  32  rt operand, forwarded value.
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

## Operation
- State machine has two states. IDLE is entered at reset. RUN holds a down-counter `cnt[3:0]`.
- In IDLE:
  - Start=1 with MDOp 1..4 launches an operation.
  - The result is computed from A/B in that cycle and captured into internal temp registers `tHI/tLO` at the edge.
  - `cnt` loads MULT_CYCLES for mult/multu or DIV_CYCLES for div/divu.
  - The state moves to RUN and Busy rises.
- In RUN:
  - `cnt` decrements by 1 each edge.
  - On the edge where `cnt`==1, HI←tHI, LO←tLO, Busy falls and the state returns to IDLE.
- mthi/mtlo:
  - MDOp 5 writes HI←A and MDOp 6 writes LO←A at the next edge.
  - These take effect only in IDLE with Start=0; Start is not required for them.
  - No Busy is generated.
- Arithmetic:
  - mult: signed 64-bit product {HI,LO}=$signed(A)*$signed(B).
  - multu: unsigned 64-bit product.
  - div: LO=quotient truncated toward zero; HI=remainder, carrying the sign of the dividend A.
  - divu: unsigned quotient and remainder.
- Divide by zero (B==0, div/divu): timing is unchanged and Busy still lasts DIV_CYCLES cycles. At completion HI/LO keep their previous values.
- Protocol violations:
  - Start, or MDOp 5/6, arriving while Busy=1 is ignored. The in-flight operation and HI/LO are unaffected.
  - Stall control must prevent this. The bench checks that the block ignores it.
- Start=1 with MDOp 0, 5, 6 or 7 is ignored for launch. MDOp 5/6 with Start=1 is also ignored.
- Reset, asserted at any time including mid-operation:
  - HI=0, LO=0, Busy=0, cnt=0, tHI=tLO=0, state IDLE.
  - Any pending result is discarded.

## Timing
- Start sampled at edge T0 → Busy=1 during cycles T0+1 … T0+N, where N=MULT_CYCLES or DIV_CYCLES.
- HI/LO update at edge T0+N. Busy=0 from that same edge onward.
- A new Start is accepted in cycle T0+N+1 at the earliest, in the cycle after Busy falls. There are no back-to-back launches without one IDLE cycle.
- mthi/mtlo take 1 cycle: the value is visible on HI/LO in the cycle after the write cycle.
- HI/LO are registered outputs, with no combinational path from A/B.
- Busy depends only on state: it is never combinational from Start.
- Stall control uses (Start|Busy) on its own side.
- A read of HI/LO in the cycle after completion sees the new values.

## Test plan
- mult A=0xFFFFFFFD (-3), B=5 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Also mult with the same operands → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → Busy high exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Edge cases:
  - divu A=7, B=3 → LO=2, HI=1.
  - Then divu with B=0 → Busy 10 cycles and HI=1, LO=2 unchanged.
- Ignored inputs during an operation:
  - mthi A=0x12345678 in IDLE → HI=0x12345678 next cycle, Busy stays 0.
  - During a running mult, mtlo A=0xDEADBEEF and a second Start are both ignored.
  - LO ends up equal to the mult result.
- Reset mid-operation:
  - Assert reset low asynchronously (mid-cycle) in the 4th busy cycle of a div → Busy, HI and LO go to 0 immediately.
  - After release, no late write occurs.
  - A fresh mult completes normally with 5-cycle latency.
